// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch-stage controller between a variable-latency imem and InstrF
//
// Issues one instruction-memory request per fetch PC, holds the returned word
// and presents it on InstrF. FetchStall is raised while no word is held.
// Responses for requests that turned out to be on the wrong path (a taken
// branch/jump seen in Execute while the request was in flight) are dropped.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   PCF                 current fetch PC
//   StallF, PCSrcE      final fetch stall / taken redirect from Execute
//   imem_req_valid      request strobe (only while no request is outstanding)
//   imem_req_addr       request address (follows PCF combinationally)
//   imem_req_ready      memory accepts the request this cycle
//   imem_resp_valid     one-cycle response pulse, imem_resp_data carries the word
//   InstrF              held word, or NOP_INSTR while nothing valid is held
//   FetchStall          no valid word held (state-only, no path from StallF)
//   fetch_stall_cycles  saturating count of cycles with FetchStall=1
module instr_fetch_unit #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  NOP_INSTR = 32'h00000013,
  parameter int unsigned      CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  PCF,
  input  logic             StallF,
  input  logic             PCSrcE,
  output logic             imem_req_valid,
  output logic [XLEN-1:0]  imem_req_addr,
  input  logic             imem_req_ready,
  input  logic             imem_resp_valid,
  input  logic [XLEN-1:0]  imem_resp_data,
  output logic [XLEN-1:0]  InstrF,
  output logic             FetchStall,
  output logic [CNT_W-1:0] fetch_stall_cycles
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_VALID = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state_q, state_d;
  logic              kill_q, kill_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              kill_eff;

  // A redirect in the same cycle as the response also makes it wrong-path.
  assign kill_eff = kill_q | PCSrcE;

  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    instr_d = instr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (imem_req_ready) begin
          state_d = ST_WAIT;
          // Accepted while redirecting: the PC presented was the wrong path.
          kill_d  = PCSrcE;
        end
      end
      ST_WAIT: begin
        kill_d = kill_eff;
        if (imem_resp_valid) begin
          if (kill_eff) begin
            kill_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            instr_d = imem_resp_data;
            state_d = ST_VALID;
          end
        end
      end
      ST_VALID: begin
        if (!StallF || PCSrcE) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        kill_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (FetchStall && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      kill_q  <= 1'b0;
      instr_q <= NOP_INSTR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_req_valid     = (state_q == ST_IDLE);
  assign imem_req_addr      = PCF;
  assign FetchStall         = (state_q != ST_VALID);
  assign InstrF             = (state_q == ST_VALID) ? instr_q : NOP_INSTR;
  assign fetch_stall_cycles = cnt_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch-stage controller between a variable-latency instruction memory (valid/ready request, valid response) and the pipelined datapath's InstrF input.
- Issues one request per PCF, holds the returned word, and presents it as InstrF.
- Raises FetchStall while no word is held; the hazard unit merges FetchStall into StallF/StallD/FlushE.
- Discards wrong-path responses after a taken branch/jump (PCSrcE).

Parameters:
- XLEN, 32, address/instruction width.
- NOP_INSTR, 32'h00000013, InstrF value whenever no valid word is held (addi x0,x0,0).
- CNT_W, 32, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- PCF  in  XLEN  current fetch PC from the PC register.
- StallF  in  1  final fetch stall from the hazard unit; PCF changes only when 0 or when PCSrcE=1.
- PCSrcE  in  1  taken branch/jump in Execute; PCF becomes the target next cycle.
- imem_req_valid  out  1  request strobe.
- imem_req_addr  out  XLEN  request address.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_resp_valid  in  1  response word valid, one cycle pulse per accepted request.
- imem_resp_data  in  XLEN  response word.
- InstrF  out  XLEN  instruction to the Decode register.
- FetchStall  out  1  no valid instruction held.
- fetch_stall_cycles  out  CNT_W  cycles with FetchStall=1.

Behaviour:
- Reset (async): state=IDLE, kill=0, instr_q=NOP_INSTR, fetch_stall_cycles=0. Outputs: imem_req_valid=1 (IDLE), FetchStall=1, InstrF=NOP_INSTR.
- Only one request is outstanding at a time.
- imem_req_addr=PCF, combinational.
- FetchStall=(state!=VALID). It depends on state only and never on StallF, so there is no combinational loop through the hazard unit.
- Hazard-unit contract (decided): StallF = lwStall | (FetchStall & ~PCSrcE), StallD = lwStall | FetchStall, FlushE = lwStall | FetchStall | PCSrcE.
- IDLE: imem_req_valid=1.
  - On imem_req_ready, go to WAIT with kill<=PCSrcE, because a request accepted while PCSrcE=1 carries a wrong-path PC.
  - Otherwise stay in IDLE, re-presenting PCF, which may change after a redirect.
- WAIT: imem_req_valid=0. kill<=kill|PCSrcE.
  - On imem_resp_valid with effective kill (kill|PCSrcE)=0: instr_q<=imem_resp_data, go to VALID.
  - On imem_resp_valid with effective kill=1: discard the word, kill<=0, go to IDLE.
- VALID: InstrF=instr_q, imem_req_valid=0.
  - If StallF=0 or PCSrcE=1: the word is consumed or squashed, go to IDLE (the next request issues the following cycle).
  - If StallF=1 and PCSrcE=0: hold state and instr_q unchanged.
- InstrF=NOP_INSTR in IDLE and WAIT.
- imem_resp_valid in IDLE or VALID is ignored; this covers stale responses after reset.
- Counter: increments each cycle FetchStall=1 and saturates at all-ones; it does not wrap.
- Minimum latency: request accepted cycle N, response cycle N+1, InstrF valid cycle N+2. Steady-state throughput is one instruction per 3 cycles for 1-cycle memory.
- Simultaneous events:
  - Response arriving in the same cycle as PCSrcE in WAIT is discarded.
  - req_ready together with PCSrcE in IDLE sets kill.

Test Plan:
- Reset mid-WAIT, then resp_valid=1 next cycle -> state IDLE, response ignored, InstrF=32'h00000013, counter=0.
- PCF=0x0, req_ready=1 immediately, response 0x00500093 one cycle later, StallF=0 -> imem_req_addr=0x0 cycle 0, InstrF=0x00500093 and FetchStall=0 cycle 2, IDLE cycle 3.
- VALID holding 0x00A00113 with StallF=1 for 4 cycles -> InstrF stays 0x00A00113, FetchStall=0 throughout, no new request.
- PCSrcE=1 one cycle after acceptance of PCF=0x10, response 0xDEADBEEF arrives 3 cycles later -> word discarded, returns to IDLE, next request uses target PCF=0x40.
- req_ready=1 coincident with PCSrcE=1 in IDLE -> kill set, that response dropped, InstrF remains 32'h00000013.
- Memory with req_ready low for 5 cycles then 1-cycle response -> FetchStall=1 for 7 cycles, fetch_stall_cycles=7; preload counter near all-ones -> it saturates and does not wrap.
